// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM write port of the program loader.
// The master modport is the loader's view; slave is the host/memory view.
interface prog_loader_if #(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             we;
  logic [Psize-1:0] waddr;
  logic [Isize-1:0] wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program memory loader: assembles an MSB-first byte stream into Isize-bit words and
// writes them from address 0, holding the CPU in reset. Optional PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic          err
);

  localparam int unsigned BPW   = Isize / 8;
  localparam int unsigned BIW   = $clog2(BPW + 1);
  localparam int unsigned DEPTH = 1 << Psize;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BYTE,
    S_WRITE,
    S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t           state_q, state_n;
  logic [Psize-1:0] nlast_q, nlast_n;
  logic [Psize-1:0] waddr_q, waddr_n;
  logic [BIW-1:0]   bidx_q, bidx_n;
  logic [Isize-1:0] wdata_q, wdata_n;
  logic [Isize-1:0] word_next;
  logic             xfer;
  logic             shift_en;
  logic             in_ready_q, in_ready_n;
  logic             we_q, we_n;
  logic             busy_n, done_n, hold_n;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_n;
  logic       err_q, err_n;
`endif

  assign xfer         = bus.in_valid && in_ready_q;
  assign shift_en     = xfer && (state_q == S_BYTE);
  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

  // Only the first BPW-1 bytes need storage; the last byte goes straight into wdata.
  if (BPW > 1) begin : g_asm
    logic [Isize-9:0] asm_q;

    assign word_next = {asm_q, bus.in_data};

    always_ff @(posedge clk) begin
      if (reset) begin
        asm_q <= '0;
      end else if (shift_en) begin
        asm_q <= word_next[Isize-9:0];
      end
    end
  end else begin : g_noasm
    assign word_next = bus.in_data;
  end

  always_comb begin
    state_n = state_q;
    nlast_n = nlast_q;
    waddr_n = waddr_q;
    bidx_n  = bidx_q;
    wdata_n = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_n  = csum_q;
    err_n   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_LEN;
        end
      end

      S_LEN: begin
        if (xfer) begin
          // Zero and oversize counts both mean a full-depth load.
          if ((bus.in_data == 8'd0) || (32'(bus.in_data) > DEPTH)) begin
            nlast_n = Psize'(DEPTH - 1);
          end else begin
            nlast_n = Psize'(32'(bus.in_data) - 32'd1);
          end
          bidx_n  = '0;
          waddr_n = '0;
          state_n = S_BYTE;
        end
      end

      S_BYTE: begin
        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_n = csum_q ^ bus.in_data;
`endif
          if (bidx_q == BIW'(BPW - 1)) begin
            bidx_n  = '0;
            wdata_n = word_next;
            state_n = S_WRITE;
          end else begin
            bidx_n = bidx_q + BIW'(1);
          end
        end
      end

      S_WRITE: begin
        if (waddr_q == nlast_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n = S_CSUM;
`else
          state_n = S_DONE;
`endif
        end else begin
          waddr_n = waddr_q + Psize'(1);
          state_n = S_BYTE;
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          err_n   = (bus.in_data != csum_q);
          state_n = S_DONE;
        end
      end
`endif

      S_DONE: begin
        if (start) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          err_n  = 1'b0;
          csum_n = '0;
`endif
          state_n = S_LEN;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    in_ready_n = (state_n == S_LEN) || (state_n == S_BYTE);
`ifdef PROG_LOADER_CHECKSUM_EN
    in_ready_n = in_ready_n || (state_n == S_CSUM);
`endif
    we_n   = (state_n == S_WRITE);
    done_n = (state_n == S_DONE);
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    hold_n = (state_n != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      nlast_q    <= '0;
      waddr_q    <= '0;
      bidx_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state_q    <= state_n;
      nlast_q    <= nlast_n;
      waddr_q    <= waddr_n;
      bidx_q     <= bidx_n;
      wdata_q    <= wdata_n;
      in_ready_q <= in_ready_n;
      we_q       <= we_n;
      busy       <= busy_n;
      done       <= done_n;
      cpu_hold   <= hold_n;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_n;
      err_q  <= err_n;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected RAM writes, a negedge
// monitor pops and compares them whenever we is high.
module tb_prog_loader;

  localparam int unsigned PS = 6;
  localparam int unsigned IS = 24;

  logic clk;
  logic reset;
  logic start;
  logic busy, done, cpu_hold, err;

  prog_loader_if #(.Psize(PS), .Isize(IS)) bus ();

  prog_loader #(.Psize(PS), .Isize(IS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .cpu_hold(cpu_hold),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PS-1:0] a;
    logic [IS-1:0] d;
  } wr_t;

  wr_t      exp_q[$];
  wr_t      mon_e;
  int       tests = 0;
  int       fails = 0;
  logic [7:0] tb_csum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && bus.we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got waddr=%0d wdata=%06h required no write", bus.waddr, bus.wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.waddr), 32'(mon_e.a));
        chk("wr_data", 32'(bus.wdata), 32'(mon_e.d));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready) begin
      if (t >= 200) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: got in_ready=0 for %0d cycles required 1", t);
        break;
      end
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [IS-1:0] w, input logic [PS-1:0] addr,
                           input int gap_first, input int gap_rest);
    logic [7:0] b;
    exp_q.push_back('{a: addr, d: w});
    for (int k = 0; k < 3; k++) begin
      b = w[23-8*k -: 8];
      tb_csum = tb_csum ^ b;
      send_byte(b, (k == 0) ? gap_first : gap_rest);
    end
  endtask

  task automatic begin_load();
    tb_csum = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Called at the negedge of the last WRITE cycle.
  task automatic finish_load(input logic [7:0] csum_byte);
    logic exp_err;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_err = (csum_byte != tb_csum);
    send_byte(csum_byte, 0);
`else
    exp_err = 1'b0;
    @(negedge clk);
`endif
    chk("done", 32'(done), 32'd1);
    chk("done_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    chk("done_err", 32'(err), 32'(exp_err));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tb_csum      = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Start with no bytes: waits in LEN
    begin_load();
    for (int i = 0; i < 3; i++) begin
      chk("len_busy", 32'(busy), 32'd1);
      chk("len_in_ready", 32'(bus.in_ready), 32'd1);
      chk("len_we", 32'(bus.we), 32'd0);
      @(negedge clk);
    end

    // Basic load (start while busy is ignored)
    begin_load();
    send_byte(8'h02, 0);
    send_word(24'h123456, 6'd0, 0, 0);
    send_word(24'hABCDEF, 6'd1, 0, 0);
    finish_load(tb_csum);

    // Stalled source; first byte of word 1 is presented during the WRITE cycle
    begin_load();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h02, 5);
    send_word(24'h123456, 6'd0, 5, 5);
    send_word(24'hABCDEF, 6'd1, 0, 5);
    finish_load(tb_csum);

    // Full depth: count 0 means 64 words
    begin_load();
    send_byte(8'h00, 0);
    for (int i = 0; i < 64; i++) begin
      send_word({3{8'(i)}}, 6'(i), 0, 0);
    end
    finish_load(tb_csum);
    chk("full_last_waddr", 32'(bus.waddr), 32'd63);

    // Abort after 2 of 3 words, then restart
    begin_load();
    send_byte(8'h03, 0);
    send_word(24'h010203, 6'd0, 0, 0);
    send_word(24'h040506, 6'd1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_waddr", 32'(bus.waddr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    begin_load();
    send_byte(8'h01, 0);
    exp_q.push_back('{a: 6'd0, d: 24'hAABBCC});
    tb_csum = 8'hAA ^ 8'hBB ^ 8'hCC;
    send_byte(8'hAA, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    finish_load(tb_csum);
    chk("abort_final_waddr", 32'(bus.waddr), 32'd0);

    // Checksum good and bad (err stays 0 without the feature)
    begin_load();
    send_byte(8'h01, 0);
    send_word(24'h112233, 6'd0, 0, 0);
    finish_load(8'h00);
    begin_load();
    chk("restart_err_clr", 32'(err), 32'd0);
    send_byte(8'h01, 0);
    send_word(24'h112233, 6'd0, 0, 0);
    finish_load(8'h01);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
